// File: rtl/cnn_pkg.sv
// Shared sizing constants and types for the CNN layer control blocks.
package cnn_pkg;
  localparam int MAX_FILTERNUM   = 64;
  localparam int MAX_KERNELNUM   = 8;
  localparam int FILTERNUM_WIDTH = $clog2(MAX_FILTERNUM) + 1;
  localparam int KERNELNUM_WIDTH = $clog2(MAX_KERNELNUM) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_e;

  typedef struct packed {
    logic [FILTERNUM_WIDTH-1:0] num_filter;
    logic [KERNELNUM_WIDTH-1:0] num_kernel;
  } pass_cfg_t;

  // Counts above the array size saturate instead of being rejected.
  function automatic pass_cfg_t clamp_cfg(input logic [FILTERNUM_WIDTH-1:0] nf,
                                          input logic [KERNELNUM_WIDTH-1:0] nk);
    pass_cfg_t c;
    c.num_filter = (nf > FILTERNUM_WIDTH'(MAX_FILTERNUM)) ? FILTERNUM_WIDTH'(MAX_FILTERNUM) : nf;
    c.num_kernel = (nk > KERNELNUM_WIDTH'(MAX_KERNELNUM)) ? KERNELNUM_WIDTH'(MAX_KERNELNUM) : nk;
    return c;
  endfunction
endpackage

// File: rtl/load_counter.sv
// Nested kernel/filter beat counter; kernel index is the inner loop.
module load_counter
  import cnn_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       adv,
  input  logic [FILTERNUM_WIDTH-1:0] num_filter,
  input  logic [KERNELNUM_WIDTH-1:0] num_kernel,
  output logic [FILTERNUM_WIDTH-1:0] filter_cnt,
  output logic [KERNELNUM_WIDTH-1:0] kernel_cnt,
  output logic                       last
);
  logic kernel_last, filter_last;

  assign kernel_last = (kernel_cnt == num_kernel - KERNELNUM_WIDTH'(1));
  assign filter_last = (filter_cnt == num_filter - FILTERNUM_WIDTH'(1));
  assign last        = kernel_last && filter_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filter_cnt <= '0;
      kernel_cnt <= '0;
    end else if (clear) begin
      filter_cnt <= '0;
      kernel_cnt <= '0;
    end else if (adv) begin
      if (kernel_last) begin
        kernel_cnt <= '0;
        filter_cnt <= filter_last ? '0 : filter_cnt + FILTERNUM_WIDTH'(1);
      end else begin
        kernel_cnt <= kernel_cnt + KERNELNUM_WIDTH'(1);
      end
    end
  end
endmodule

// File: rtl/filter_load_ctrl.sv
// Layer-pass sequencer: streams filter weights into the PE array, then holds
// the array in compute until the datapath reports completion.
module filter_load_ctrl
  import cnn_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [FILTERNUM_WIDTH-1:0] cfg_num_filter,
  input  logic [KERNELNUM_WIDTH-1:0] cfg_num_kernel,
  input  logic                       w_valid,
  output logic                       w_ready,
  output logic                       pe_we,
  input  logic                       compute_done,
  output logic [FILTERNUM_WIDTH-1:0] filter_cnt,
  output logic [KERNELNUM_WIDTH-1:0] kernel_cnt,
  output logic                       filter_load,
  output logic [FILTERNUM_WIDTH-1:0] num_filter,
  output logic [KERNELNUM_WIDTH-1:0] num_kernel,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);
  state_e    state, state_nxt;
  pass_cfg_t cfg_in, cfg_q;
  logic      cfg_zero, take, go, last;

  assign cfg_in   = clamp_cfg(cfg_num_filter, cfg_num_kernel);
  assign cfg_zero = (cfg_in.num_filter == '0) || (cfg_in.num_kernel == '0);
  assign take     = (state == IDLE) && start;
  assign go       = take && !cfg_zero;

  assign w_ready    = (state == LOAD);
  assign pe_we      = w_valid & w_ready;
  assign num_filter = cfg_q.num_filter;
  assign num_kernel = cfg_q.num_kernel;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = cfg_zero ? DONE : LOAD;
      LOAD:    if (pe_we && last) state_nxt = COMPUTE;
      COMPUTE: if (compute_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q       <= '0;
      filter_load <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      if (take) cfg_q <= cfg_in;
      filter_load <= (state_nxt != LOAD);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
      cfg_err     <= take && cfg_zero;
    end
  end

  load_counter u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear      (go),
    .adv        (pe_we),
    .num_filter (cfg_q.num_filter),
    .num_kernel (cfg_q.num_kernel),
    .filter_cnt (filter_cnt),
    .kernel_cnt (kernel_cnt),
    .last       (last)
  );
endmodule

// File: tb/tb_filter_load_ctrl.sv
// Scoreboard bench for filter_load_ctrl: expected beats and pass endings are
// queued by the stimulus and consumed by a negedge monitor.
module tb_filter_load_ctrl;
  import cnn_pkg::*;
  localparam int FW = FILTERNUM_WIDTH;
  localparam int KW = KERNELNUM_WIDTH;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, w_valid = 1'b0, compute_done = 1'b0;
  logic [FW-1:0] cfg_num_filter = '0;
  logic [KW-1:0] cfg_num_kernel = '0;
  logic          w_ready, pe_we, filter_load, busy, done, cfg_err;
  logic [FW-1:0] filter_cnt, num_filter;
  logic [KW-1:0] kernel_cnt, num_kernel;

  typedef struct { int f; int k; } beat_t;
  typedef struct { bit err; int nf; int nk; } end_t;
  beat_t beat_q[$];
  end_t  end_q[$];
  beat_t mb;
  end_t  me;
  int    errors = 0, checks = 0;

  always #5 clk = ~clk;

  filter_load_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_num_filter(cfg_num_filter), .cfg_num_kernel(cfg_num_kernel),
    .w_valid(w_valid), .w_ready(w_ready), .pe_we(pe_we), .compute_done(compute_done),
    .filter_cnt(filter_cnt), .kernel_cnt(kernel_cnt), .filter_load(filter_load),
    .num_filter(num_filter), .num_kernel(num_kernel),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rst_ok();
    return int'(filter_cnt == '0 && kernel_cnt == '0 && num_filter == '0 && num_kernel == '0 &&
                filter_load && !busy && !done && !cfg_err && !w_ready && !pe_we);
  endfunction

  function automatic int cnt_code();
    return int'(filter_cnt) * 16 + int'(kernel_cnt);
  endfunction

  // Monitor: a beat seen here is accepted on the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      if (pe_we) begin
        if (beat_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          mb = beat_q.pop_front();
          chk("beat_cnt", cnt_code(), mb.f * 16 + mb.k);
        end
      end else if (w_ready && beat_q.size() != 0) begin
        chk("bubble_hold", cnt_code(), beat_q[0].f * 16 + beat_q[0].k);
      end
      if (done) begin
        if (end_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          me = end_q.pop_front();
          chk("done_cfg", int'(cfg_err) * 4096 + int'(num_filter) * 16 + int'(num_kernel),
              int'(me.err) * 4096 + me.nf * 16 + me.nk);
          chk("done_beats_left", beat_q.size(), 0);
          chk("done_busy", int'(busy), 1);
        end
      end else if (cfg_err) begin
        chk("cfg_err_without_done", 1, 0);
      end
    end
  end

  task automatic recover();
    reset = 1'b0;
    #2;
    beat_q.delete();
    end_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic run_pass(input int f, input int k, input bit rnd, input bit inject);
    int nf, nk, c;
    nf = (f > MAX_FILTERNUM) ? MAX_FILTERNUM : f;
    nk = (k > MAX_KERNELNUM) ? MAX_KERNELNUM : k;
    for (int fi = 0; fi < nf; fi++)
      for (int ki = 0; ki < nk; ki++) beat_q.push_back('{fi, ki});
    end_q.push_back('{1'b0, nf, nk});
    cfg_num_filter = FW'(f);
    cfg_num_kernel = KW'(k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("load_entry", int'(w_ready) * 4 + int'(filter_load) * 2 + int'(busy), 5);
    c = 0;
    while (beat_q.size() != 0 && c < nf * nk * 8 + 50) begin
      w_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = inject && (c == 3);
      cfg_num_filter = start ? FW'(5) : FW'(f);
      cfg_num_kernel = start ? KW'(3) : KW'(k);
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    if (beat_q.size() != 0) begin
      chk("load_timeout", beat_q.size(), 0);
      recover();
      return;
    end
    chk("compute_filter_load", int'(filter_load), 1);
    chk("compute_cnt_zero", cnt_code(), 0);
    // Keep offering words and poke start while computing; neither may act.
    w_valid = 1'b1;
    start = inject;
    cfg_num_filter = FW'(7);
    cfg_num_kernel = KW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    chk("compute_no_ready", int'(w_ready) * 2 + int'(pe_we), 0);
    chk("compute_busy", int'(busy) * 2 + int'(filter_load), 3);
    chk("cfg_held", int'(num_filter) * 16 + int'(num_kernel), nf * 16 + nk);
    compute_done = 1'b1;
    @(posedge clk); #1;
    compute_done = 1'b0;
    w_valid = 1'b0;
    chk("done_pulse", int'(done), 1);
    @(posedge clk); #1;
    chk("idle_after_done", int'(busy) * 2 + int'(done), 0);
    chk("done_consumed", end_q.size(), 0);
  endtask

  task automatic zero_pass(input int f, input int k);
    end_q.push_back('{1'b1, f, k});
    cfg_num_filter = FW'(f);
    cfg_num_kernel = KW'(k);
    start = 1'b1;
    w_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_cfg_flags", int'(w_ready) * 4 + int'(cfg_err) * 2 + int'(done), 3);
    chk("zero_cfg_state", int'(busy) * 2 + int'(filter_load), 3);
    @(posedge clk); #1;
    w_valid = 1'b0;
    chk("zero_cfg_idle", int'(busy) * 4 + int'(w_ready) * 2 + int'(done), 0);
    chk("zero_cfg_consumed", end_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom_range(0, 1));
      w_valid = 1'($urandom_range(0, 1));
      compute_done = 1'($urandom_range(0, 1));
      cfg_num_filter = FW'($urandom_range(0, 127));
      cfg_num_kernel = KW'($urandom_range(0, 15));
      @(posedge clk); #1;
      chk("reset_vals", rst_ok(), 1);
    end
    start = 1'b0;
    w_valid = 1'b0;
    compute_done = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("post_reset_idle", rst_ok(), 1);
    end

    run_pass(2, 3, 1'b0, 1'b0);
    run_pass(4, 2, 1'b1, 1'b0);
    run_pass(3, 2, 1'b1, 1'b1);
    zero_pass(3, 0);
    zero_pass(0, 5);
    run_pass(64, 8, 1'b0, 1'b0);
    run_pass(100, 1, 1'b0, 1'b0);

    // Abort mid-load: outputs drop asynchronously and no done follows.
    for (int fi = 0; fi < 4; fi++)
      for (int ki = 0; ki < 4; ki++) beat_q.push_back('{fi, ki});
    cfg_num_filter = FW'(4);
    cfg_num_kernel = KW'(4);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w_valid = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("abort_async", rst_ok(), 1);
    chk("abort_beats_seen", beat_q.size(), 11);
    beat_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      compute_done = 1'(i % 2);
      @(posedge clk); #1;
    end
    compute_done = 1'b0;
    w_valid = 1'b0;
    chk("abort_quiet", int'(busy) * 4 + int'(done) * 2 + int'(w_ready), 0);
    chk("abort_reset_vals", rst_ok(), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
